// File: rtl/comet2_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comet2_mem_pkg : command encodings, FSM states and word width.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package comet2_mem_pkg;

    localparam int c_word_w = 16;

    localparam logic [1:0] c_cmd_read   = 2'b00;
    localparam logic [1:0] c_cmd_write  = 2'b01;
    localparam logic [1:0] c_cmd_fetch2 = 2'b10;
    localparam logic [1:0] c_cmd_rsvd   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RD2  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Reserved encoding behaves as a plain READ.
    function automatic logic cmd_is_write(input logic [1:0] cmd);
        case (cmd)
            c_cmd_write:                          return 1'b1;
            c_cmd_read, c_cmd_fetch2, c_cmd_rsvd: return 1'b0;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_master : request/response master driving a single-port style RAM |
// | Optional address check: MEM_MASTER_ADDR_CHECK_EN.        Rev 1.0     |
// +----------------------------------------------------------------------+
module mem_master
    import comet2_mem_pkg::*;
#(
    parameter logic [c_word_w-1:0] ADDR_LIMIT = 16'h0080
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_cmd,
    input  logic [c_word_w-1:0] req_addr,
    input  logic [c_word_w-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [c_word_w-1:0] resp_data0,
    output logic [c_word_w-1:0] resp_data1,
    output logic                resp_err,
    output logic                mem_re,
    output logic                mem_we,
    output logic [c_word_w-1:0] mem_raddr,
    output logic [c_word_w-1:0] mem_waddr,
    output logic [c_word_w-1:0] mem_wdata,
    input  logic [c_word_w-1:0] mem_rdata
);

    state_t                state_q;
    logic                  fetch2_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  mem_re_q;
    logic                  mem_we_q;
    logic [c_word_w-1:0]   resp_data0_q;
    logic [c_word_w-1:0]   resp_data1_q;
    logic [c_word_w-1:0]   mem_raddr_q;
    logic [c_word_w-1:0]   mem_waddr_q;
    logic [c_word_w-1:0]   mem_wdata_q;

    logic                  w_is_fetch2;
    logic                  w_illegal;

    assign w_is_fetch2 = (req_cmd == c_cmd_fetch2);

`ifdef MEM_MASTER_ADDR_CHECK_EN
    logic                  resp_err_q;
    logic [c_word_w-1:0]   w_req_addr_inc;

    assign w_req_addr_inc = req_addr + 16'd1;
    assign w_illegal      = (req_addr >= ADDR_LIMIT) ||
                            (w_is_fetch2 && (w_req_addr_inc >= ADDR_LIMIT));
    assign resp_err       = resp_err_q;
`else
    assign w_illegal      = 1'b0;
    assign resp_err       = 1'b0 & (ADDR_LIMIT == '0);
`endif

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch2_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_data0_q <= '0;
            resp_data1_q <= '0;
            mem_raddr_q  <= '0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
`ifdef MEM_MASTER_ADDR_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q  <= 1'b0;
                        fetch2_q     <= w_is_fetch2;
                        resp_data0_q <= '0;
                        resp_data1_q <= '0;
`ifdef MEM_MASTER_ADDR_CHECK_EN
                        resp_err_q   <= w_illegal;
`endif
                        if (w_illegal) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else if (cmd_is_write(req_cmd)) begin
                            state_q     <= ST_WR;
                            mem_we_q    <= 1'b1;
                            mem_waddr_q <= req_addr;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q     <= ST_RD;
                            mem_re_q    <= 1'b1;
                            mem_raddr_q <= req_addr;
                        end
                    end
                end
                ST_RD: begin
                    resp_data0_q <= mem_rdata;
                    if (fetch2_q) begin
                        state_q     <= ST_RD2;
                        mem_raddr_q <= mem_raddr_q + 16'd1;
                    end else begin
                        state_q      <= ST_RESP;
                        mem_re_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_RD2: begin
                    resp_data1_q <= mem_rdata;
                    state_q      <= ST_RESP;
                    mem_re_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                ST_WR: begin
                    state_q      <= ST_RESP;
                    mem_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
`ifdef MEM_MASTER_ADDR_CHECK_EN
                        resp_err_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    mem_re_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data0 = resp_data0_q;
    assign resp_data1 = resp_data1_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_raddr  = mem_raddr_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_master : directed self-checking bench for mem_master.          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_mem_master;

    logic        mclk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data0;
    logic [15:0] resp_data1;
    logic        resp_err;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_raddr;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    mem_master #(.ADDR_LIMIT(16'h0080)) dut (
        .mclk       (mclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data0 (resp_data0),
        .resp_data1 (resp_data1),
        .resp_err   (resp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (mem_we) ram[mem_waddr] = mem_wdata;
    end
    assign mem_rdata = mem_re ? ram[mem_raddr] : 16'h0000;

    // Handshake one request; returns 1 ns after the accepting posedge.
    task automatic send_req(input logic [1:0] cmd, input logic [15:0] addr, input logic [15:0] wdata);
        @(negedge mclk);
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge mclk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat = negedge count after handshake at which resp_valid is first seen (0 = timeout).
    task automatic wait_resp(output int lat, output int re_n, output int we_n, output int both_n,
                             output logic [15:0] ra1, output logic [15:0] ra2);
        lat = 0; re_n = 0; we_n = 0; both_n = 0; ra1 = 16'hxxxx; ra2 = 16'hxxxx;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge mclk);
            if (mem_re) re_n++;
            if (mem_we) we_n++;
            if (mem_re && mem_we) both_n++;
            if (n == 1) ra1 = mem_raddr;
            if (n == 2) ra2 = mem_raddr;
            if (resp_valid) lat = n;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge mclk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge mclk);
        rst = 1'b0;
        @(negedge mclk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_checks++; if ({mem_re, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b want 00", {mem_re, mem_we}); end
        n_checks++; if ({mem_raddr, mem_waddr, mem_wdata} !== 48'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", {mem_raddr, mem_waddr, mem_wdata}); end
        n_checks++; if ({resp_data0, resp_data1} !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", {resp_data0, resp_data1}); end
    endtask

    task automatic test_write_read();
        int lat, re_n, we_n, both_n;
        logic [15:0] ra1, ra2;
        send_req(2'b01, 16'h0040, 16'h1234);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", lat); end
        n_checks++; if (we_n !== 1 || re_n !== 0) begin n_fail++; $display("FAIL write_enables: got we=%0d re=%0d want we=1 re=0", we_n, re_n); end
        n_checks++; if (ram[16'h0040] !== 16'h1234) begin n_fail++; $display("FAIL write_ram: got %h want 1234", ram[16'h0040]); end
        n_checks++; if ({resp_data0, resp_data1, resp_err} !== 33'h0) begin n_fail++; $display("FAIL write_resp: got %h want 0", {resp_data0, resp_data1, resp_err}); end
        finish_resp();
        @(negedge mclk);
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL write_release: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        n_checks++; if (mem_waddr !== 16'h0040 || mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL write_hold: got %h/%h want 0040/1234", mem_waddr, mem_wdata); end

        send_req(2'b00, 16'h0040, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d want 2", lat); end
        n_checks++; if (re_n !== 1 || we_n !== 0) begin n_fail++; $display("FAIL read_enables: got re=%0d we=%0d want re=1 we=0", re_n, we_n); end
        n_checks++; if (resp_data0 !== 16'h1234 || resp_err !== 1'b0) begin n_fail++; $display("FAIL read_data: got %h err=%b want 1234 err=0", resp_data0, resp_err); end
        finish_resp();

        // Reserved command must behave as READ, back-to-back with the previous response.
        send_req(2'b11, 16'h0040, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 2 || re_n !== 1 || we_n !== 0) begin n_fail++; $display("FAIL rsvd_cmd: got lat=%0d re=%0d we=%0d want 2/1/0", lat, re_n, we_n); end
        n_checks++; if (resp_data0 !== 16'h1234) begin n_fail++; $display("FAIL rsvd_data: got %h want 1234", resp_data0); end
        finish_resp();
    endtask

    task automatic test_fetch2();
        int lat, re_n, we_n, both_n;
        logic [15:0] ra1, ra2;
        ram[16'h0000] = 16'h1210;
        ram[16'h0001] = 16'ha5a5;
        send_req(2'b10, 16'h0000, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fetch2_latency: got %0d want 3", lat); end
        n_checks++; if (re_n !== 2 || both_n !== 0) begin n_fail++; $display("FAIL fetch2_enables: got re=%0d both=%0d want 2/0", re_n, both_n); end
        n_checks++; if (ra1 !== 16'h0000 || ra2 !== 16'h0001) begin n_fail++; $display("FAIL fetch2_raddr: got %h,%h want 0000,0001", ra1, ra2); end
        n_checks++; if (resp_data0 !== 16'h1210 || resp_data1 !== 16'ha5a5) begin n_fail++; $display("FAIL fetch2_data: got %h/%h want 1210/a5a5", resp_data0, resp_data1); end
        finish_resp();
    endtask

    task automatic test_stall();
        int lat, re_n, we_n, both_n;
        logic [15:0] ra1, ra2;
        send_req(2'b10, 16'h0000, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data0 !== 16'h1210 || resp_data1 !== 16'ha5a5 ||
                req_ready !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b d=%h/%h ready=%b re=%b we=%b want 1 1210/a5a5 0 0 0",
                         k, resp_valid, resp_data0, resp_data1, req_ready, mem_re, mem_we);
            end
        end
        finish_resp();
        @(negedge mclk);
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        int lat, re_n, we_n, both_n, seen;
        logic [15:0] ra1, ra2;
        send_req(2'b10, 16'h0000, 16'h0000);
        @(posedge mclk);
        #2;
        n_checks++; if (mem_re !== 1'b1 || mem_raddr !== 16'h0001) begin n_fail++; $display("FAIL midrst_in_rd2: got re=%b raddr=%h want 1/0001", mem_re, mem_raddr); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_re !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got re=%b valid=%b want 0/0", mem_re, resp_valid); end
        @(negedge mclk);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge mclk);
            if (resp_valid) seen++;
        end
        n_checks++; if (seen !== 0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_no_resp: got valid_cycles=%0d ready=%b want 0/1", seen, req_ready); end
        send_req(2'b00, 16'h0001, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 2 || resp_data0 !== 16'ha5a5) begin n_fail++; $display("FAIL midrst_next_read: got lat=%0d d=%h want 2/a5a5", lat, resp_data0); end
        finish_resp();
    endtask

`ifdef MEM_MASTER_ADDR_CHECK_EN
    task automatic test_addr_check();
        int lat, re_n, we_n, both_n;
        logic [15:0] ra1, ra2;
        send_req(2'b00, 16'h0080, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 1 || resp_err !== 1'b1 || re_n !== 0) begin n_fail++; $display("FAIL chk_read80: got lat=%0d err=%b re=%0d want 1/1/0", lat, resp_err, re_n); end
        finish_resp();
        send_req(2'b10, 16'h007F, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 1 || resp_err !== 1'b1 || re_n !== 0) begin n_fail++; $display("FAIL chk_fetch7f: got lat=%0d err=%b re=%0d want 1/1/0", lat, resp_err, re_n); end
        finish_resp();
        send_req(2'b00, 16'h007F, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (lat !== 2 || resp_err !== 1'b0 || re_n !== 1) begin n_fail++; $display("FAIL chk_read7f: got lat=%0d err=%b re=%0d want 2/0/1", lat, resp_err, re_n); end
        finish_resp();
    endtask
`else
    task automatic test_wrap();
        int lat, re_n, we_n, both_n;
        logic [15:0] ra1, ra2;
        ram[16'hFFFF] = 16'hbeef;
        ram[16'h0000] = 16'h1210;
        send_req(2'b10, 16'hFFFF, 16'h0000);
        wait_resp(lat, re_n, we_n, both_n, ra1, ra2);
        n_checks++; if (ra1 !== 16'hFFFF || ra2 !== 16'h0000) begin n_fail++; $display("FAIL wrap_raddr: got %h,%h want ffff,0000", ra1, ra2); end
        n_checks++; if (resp_data0 !== 16'hbeef || resp_data1 !== 16'h1210 || resp_err !== 1'b0) begin n_fail++; $display("FAIL wrap_data: got %h/%h err=%b want beef/1210/0", resp_data0, resp_data1, resp_err); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wrap_latency: got %0d want 3", lat); end
        finish_resp();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = 2'b00;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_fetch2();
        test_stall();
        test_reset_mid();
`ifdef MEM_MASTER_ADDR_CHECK_EN
        test_addr_check();
`else
        test_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
